// File: rtl/morse_encoder.sv
// Morse keyer: pops ASCII bytes from a FWFT FIFO and keys them
// out on morse_o with dot/dash/gap timing built from UNIT_TICKS.
module morse_encoder #(
  parameter int WORD_BITS  = 8,
  parameter int UNIT_TICKS = 10000000
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 empty_i,
  input  logic [WORD_BITS-1:0] rdata_i,
  output logic                 read_o,
  output logic                 morse_o,
  output logic                 busy_o
);

  localparam int TW = (UNIT_TICKS > 2) ? $clog2(UNIT_TICKS) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(UNIT_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MARK,
    SPACE,
    GAP
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [7:0]  char_q;
  logic [TW-1:0] tick_q;
  logic [2:0]  units_q;
  logic [2:0]  units_d;
  logic [2:0]  len_q;
  logic [4:0]  pat_q;
  logic [2:0]  idx_q;
  logic        morse_d;
  logic        busy_d;

  logic [7:0]  fold;
  logic [7:0]  lk;
  logic [2:0]  lk_len;
  logic [4:0]  lk_pat;
  logic [4:0]  lk_pat_l;
  logic        is_sym;
  logic        is_space;
  logic        unit_end;
  logic        last_unit;

  assign fold = (char_q >= 8'h61 && char_q <= 8'h7a)
              ? char_q - 8'h20 : char_q;

  // {len, pattern right-aligned, 1 = dash}
  always_comb begin
    lk = 8'h00;
    case (fold)
      8'h41: lk = {3'd2, 5'b00001};
      8'h42: lk = {3'd4, 5'b01000};
      8'h43: lk = {3'd4, 5'b01010};
      8'h44: lk = {3'd3, 5'b00100};
      8'h45: lk = {3'd1, 5'b00000};
      8'h46: lk = {3'd4, 5'b00010};
      8'h47: lk = {3'd3, 5'b00110};
      8'h48: lk = {3'd4, 5'b00000};
      8'h49: lk = {3'd2, 5'b00000};
      8'h4a: lk = {3'd4, 5'b00111};
      8'h4b: lk = {3'd3, 5'b00101};
      8'h4c: lk = {3'd4, 5'b00100};
      8'h4d: lk = {3'd2, 5'b00011};
      8'h4e: lk = {3'd2, 5'b00010};
      8'h4f: lk = {3'd3, 5'b00111};
      8'h50: lk = {3'd4, 5'b00110};
      8'h51: lk = {3'd4, 5'b01101};
      8'h52: lk = {3'd3, 5'b00010};
      8'h53: lk = {3'd3, 5'b00000};
      8'h54: lk = {3'd1, 5'b00001};
      8'h55: lk = {3'd3, 5'b00001};
      8'h56: lk = {3'd4, 5'b00001};
      8'h57: lk = {3'd3, 5'b00011};
      8'h58: lk = {3'd4, 5'b01001};
      8'h59: lk = {3'd4, 5'b01011};
      8'h5a: lk = {3'd4, 5'b01100};
      8'h30: lk = {3'd5, 5'b11111};
      8'h31: lk = {3'd5, 5'b01111};
      8'h32: lk = {3'd5, 5'b00111};
      8'h33: lk = {3'd5, 5'b00011};
      8'h34: lk = {3'd5, 5'b00001};
      8'h35: lk = {3'd5, 5'b00000};
      8'h36: lk = {3'd5, 5'b10000};
      8'h37: lk = {3'd5, 5'b11000};
      8'h38: lk = {3'd5, 5'b11100};
      8'h39: lk = {3'd5, 5'b11110};
      default: lk = 8'h00;
    endcase
  end

  assign lk_len   = lk[7:5];
  assign lk_pat   = lk[4:0];
  // left-align so the current element is always pat_q[4]
  assign lk_pat_l = lk_pat << (3'd5 - lk_len);
  assign is_sym   = (lk_len != 3'd0);
  assign is_space = (char_q == 8'h20);

  assign unit_end  = (tick_q == '0);
  assign last_unit = unit_end && (units_q == 3'd1);

  assign read_o = (state_q == IDLE) && !empty_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (!empty_i) state_d = LOOKUP;
      LOOKUP: begin
        unique case (1'b1)
          is_sym:   state_d = MARK;
          is_space: state_d = GAP;
          default:  state_d = IDLE;
        endcase
      end
      MARK: begin
        if (last_unit)
          state_d = (idx_q == len_q - 3'd1) ? GAP : SPACE;
      end
      SPACE:  if (last_unit) state_d = MARK;
      GAP:    if (last_unit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    units_d = 3'd0;
    case (state_d)
      MARK: begin
        if (state_q == LOOKUP) units_d = lk_pat_l[4] ? 3'd3 : 3'd1;
        else                   units_d = pat_q[3]    ? 3'd3 : 3'd1;
      end
      SPACE:   units_d = 3'd1;
      GAP:     units_d = (state_q == LOOKUP) ? 3'd7 : 3'd3;
      default: units_d = 3'd0;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tick_q  <= '0;
      units_q <= 3'd0;
    end else if (state_d != state_q) begin
      tick_q  <= TICK_MAX;
      units_q <= units_d;
    end else if (state_q != IDLE) begin
      if (unit_end) begin
        tick_q  <= TICK_MAX;
        units_q <= units_q - 3'd1;
      end else begin
        tick_q  <= tick_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      char_q <= 8'h00;
      len_q  <= 3'd0;
      pat_q  <= 5'd0;
      idx_q  <= 3'd0;
    end else begin
      if (read_o)
        char_q <= rdata_i[7:0];
      if (state_q == LOOKUP) begin
        len_q <= lk_len;
        pat_q <= lk_pat_l;
        idx_q <= 3'd0;
      end else if (state_q == SPACE && state_d == MARK) begin
        pat_q <= pat_q << 1;
        idx_q <= idx_q + 3'd1;
      end
    end
  end

  // morse follows the MARK state one cycle later; busy tracks the new state
  always_comb begin
    morse_d = (state_q == MARK);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      morse_o <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      morse_o <= morse_d;
      busy_o  <= busy_d;
    end
  end

endmodule
